instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of Program_Counter: takes the current PC, runs a req/ack transaction to instruction memory, and latches the returned word into an instruction register for decode.
- Drives a one-cycle PC_EN pulse so the PC advances only after a fetch completes.
- Handles redirects (FLUSH, driven by the PC_SEL jump path) and memory timeouts.

Parameters:
- ADDR_W, 32, PC / memory address width
- DATA_W, 32, instruction width
- TIMEOUT, 16, max WAIT cycles before error; 0 disables the timeout
- NOP_INSTR, 32'h00000000, value INSTR takes on reset and flush

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- PC_IN  in  ADDR_W  current PC (Program_Counter OUT)
- FLUSH  in  1  redirect; in-flight/held instruction is discarded
- PC_EN  out  1  one-cycle pulse: PC may advance
- MEM_REQ  out  1  fetch request to instruction memory
- MEM_ADDR  out  ADDR_W  fetch address, stable while MEM_REQ=1
- MEM_ACK  in  1  memory response valid
- MEM_RDATA  in  DATA_W  instruction word, sampled when MEM_ACK=1
- INSTR  out  DATA_W  latched instruction
- INSTR_PC  out  ADDR_W  address INSTR came from
- INSTR_VALID  out  1  INSTR valid for decode
- INSTR_READY  in  1  decode accepts INSTR
- FETCH_ERR  out  1  sticky timeout flag

Behaviour:
- Reset (async, any state):
  - state=IDLE, MEM_REQ=0, MEM_ADDR=0, INSTR=NOP_INSTR, INSTR_PC=0, INSTR_VALID=0, PC_EN=0, FETCH_ERR=0.
  - wait counter and flush_pending cleared.
- All outputs are registered. States: IDLE, WAIT, VALID, ERROR.
- IDLE:
  - At the next edge, if FLUSH=0: MEM_REQ<=1, MEM_ADDR<=PC_IN, counter<=0, go to WAIT.
  - FLUSH=1: remain in IDLE.
- WAIT:
  - MEM_REQ and MEM_ADDR are held constant until MEM_ACK; the counter increments each cycle.
  - On MEM_ACK=1 with no flush (flush_pending=0 and FLUSH=0):
    - INSTR<=MEM_RDATA, INSTR_PC<=MEM_ADDR, INSTR_VALID<=1, PC_EN<=1 for exactly one cycle, MEM_REQ<=0, go to VALID.
    - Latency: ack edge to INSTR_VALID is 1 cycle.
  - On MEM_ACK=1 with flush (flush_pending=1 or FLUSH=1): discard the data, MEM_REQ<=0, PC_EN stays 0, INSTR_VALID stays 0, flush_pending<=0, go to IDLE.
  - FLUSH=1 without ACK: flush_pending<=1. The transaction is never abandoned mid-handshake.
  - Counter reaches TIMEOUT (TIMEOUT≠0) without ACK: MEM_REQ<=0, FETCH_ERR<=1, go to ERROR.
- VALID:
  - INSTR, INSTR_PC and INSTR_VALID are held while INSTR_READY=0.
  - INSTR_READY=1 and FLUSH=0: INSTR_VALID<=0, go to IDLE.
  - FLUSH=1 (takes priority over READY): INSTR_VALID<=0, INSTR<=NOP_INSTR, go to IDLE.
  - The mandatory IDLE cycle guarantees PC_IN reflects the PC_EN update before the next sample.
- ERROR: all outputs idle (MEM_REQ=0, INSTR_VALID=0). Only RST exits; FETCH_ERR stays 1.
- PC_EN is never asserted in a cycle where FLUSH=1 is sampled. The jump load has priority at the PC.
- MEM_ACK while MEM_REQ=0: ignored.
- Reset mid-WAIT: MEM_REQ drops asynchronously; memory must tolerate an aborted request.
- No address arithmetic is performed here; MEM_ADDR is always a copy of PC_IN.

Test Plan:
- Reset, then PC_IN=0x00, memory acks 2 cycles after req with 0x8C010004, READY=1 → MEM_ADDR=0x00; one cycle after ACK: INSTR=0x8C010004, INSTR_PC=0x00, INSTR_VALID=1, PC_EN pulses once. The next request uses the incremented PC_IN=0x04.
- Back-to-back fetches, ack latency 0..3 random, READY always 1 → each INSTR_PC equals the PC_IN sequence 0,4,8,…; PC_EN count equals INSTR_VALID count.
- VALID with READY=0 for 5 cycles → INSTR/INSTR_PC/INSTR_VALID unchanged, no new MEM_REQ, PC_EN=0; READY=1 → INSTR_VALID=0 next cycle.
- FLUSH pulsed in WAIT, then ACK 2 cycles later with 0xDEADBEEF, PC_IN switched to JUMP=100 → INSTR_VALID stays 0, PC_EN stays 0, next MEM_ADDR=100.
- Memory never acks, TIMEOUT=16 → MEM_REQ drops and FETCH_ERR=1 after 16 WAIT cycles, stays 1; RST clears FETCH_ERR and fetching resumes.
- RST asserted asynchronously mid-WAIT (between edges) → MEM_REQ=0 and INSTR_VALID=0 immediately, INSTR=NOP_INSTR.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage that sits directly after the program counter. It takes the
// current PC, runs one req/ack transaction against instruction memory and
// latches the returned word into an instruction register for decode. The
// PC is told to advance with a one-cycle pc_en pulse, and only after a
// fetch has completed.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   pc_in        in   current PC from the program counter
//   flush        in   redirect from the jump path; discards in-flight or
//                     held instruction
//   pc_en        out  one-cycle pulse, PC may advance
//   mem_req      out  fetch request to instruction memory
//   mem_addr     out  fetch address, stable while mem_req is high
//   mem_ack      in   memory response valid
//   mem_rdata    in   instruction word, sampled when mem_ack is high
//   instr        out  latched instruction
//   instr_pc     out  address instr was fetched from
//   instr_valid  out  instr is valid for decode
//   instr_ready  in   decode accepts instr
//   fetch_err    out  sticky memory timeout flag
//
// Every output comes straight from a flop. The FSM is split into a
// combinational block that works out the next value of every register and a
// single register block that loads them.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                 ADDR_W    = 32,
  parameter int                 DATA_W    = 32,
  parameter int                 TIMEOUT   = 16,
  parameter logic [DATA_W-1:0]  NOP_INSTR = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  output logic              pc_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fetch_err
);

  // The wait counter only has to reach TIMEOUT; when the timeout is disabled
  // a single bit is kept so the logic stays well formed.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_ERROR = 2'd3
  } fetch_state_t;

  fetch_state_t state, state_nx;

  logic              mem_req_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] instr_nx;
  logic [ADDR_W-1:0] instr_pc_nx;
  logic              instr_valid_nx;
  logic              pc_en_nx;
  logic              fetch_err_nx;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nx, wait_cnt_inc;
  logic              flush_pending, flush_pending_nx;
  logic              timeout_hit;
  logic              discard_ack;

  // The timeout fires on the edge where the counter would reach TIMEOUT,
  // so mem_req is high for exactly TIMEOUT cycles in WAIT.
  assign wait_cnt_inc = wait_cnt + CNT_ONE;
  assign timeout_hit  = (TIMEOUT != 0) && (wait_cnt_inc == TIMEOUT_CNT);

  // A redirect seen earlier in this transaction, or on the ack edge itself,
  // turns the returning word into garbage that must not reach decode.
  assign discard_ack = flush_pending || flush;

  // Next-state and next-output logic. Every register holds by default and
  // pc_en defaults low so it can only ever be a single-cycle pulse. The
  // memory transaction is never abandoned mid-handshake: a redirect during
  // WAIT is only remembered, and the data is dropped when the ack arrives.
  always_comb begin
    state_nx         = state;
    mem_req_nx       = mem_req;
    mem_addr_nx      = mem_addr;
    instr_nx         = instr;
    instr_pc_nx      = instr_pc;
    instr_valid_nx   = instr_valid;
    pc_en_nx         = 1'b0;
    fetch_err_nx     = fetch_err;
    wait_cnt_nx      = wait_cnt;
    flush_pending_nx = flush_pending;

    unique case (state)
      S_IDLE: begin
        mem_req_nx     = 1'b0;
        instr_valid_nx = 1'b0;
        if (!flush) begin
          mem_req_nx       = 1'b1;
          mem_addr_nx      = pc_in;
          wait_cnt_nx      = '0;
          flush_pending_nx = 1'b0;
          state_nx         = S_WAIT;
        end
      end

      S_WAIT: begin
        if (mem_ack) begin
          mem_req_nx       = 1'b0;
          flush_pending_nx = 1'b0;
          if (discard_ack) begin
            state_nx = S_IDLE;
          end else begin
            instr_nx       = mem_rdata;
            instr_pc_nx    = mem_addr;
            instr_valid_nx = 1'b1;
            pc_en_nx       = 1'b1;
            state_nx       = S_VALID;
          end
        end else if (timeout_hit) begin
          mem_req_nx       = 1'b0;
          fetch_err_nx     = 1'b1;
          flush_pending_nx = 1'b0;
          state_nx         = S_ERROR;
        end else begin
          wait_cnt_nx = wait_cnt_inc;
          if (flush) begin
            flush_pending_nx = 1'b1;
          end
        end
      end

      S_VALID: begin
        // The mandatory trip through IDLE gives the PC one edge to load the
        // value requested by pc_en before it is sampled again.
        if (flush) begin
          instr_valid_nx = 1'b0;
          instr_nx       = NOP_INSTR;
          state_nx       = S_IDLE;
        end else if (instr_ready) begin
          instr_valid_nx = 1'b0;
          state_nx       = S_IDLE;
        end
      end

      S_ERROR: begin
        mem_req_nx     = 1'b0;
        instr_valid_nx = 1'b0;
        fetch_err_nx   = 1'b1;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous so an in-flight
  // request drops immediately; memory has to tolerate the aborted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      instr         <= NOP_INSTR;
      instr_pc      <= '0;
      instr_valid   <= 1'b0;
      pc_en         <= 1'b0;
      fetch_err     <= 1'b0;
      wait_cnt      <= '0;
      flush_pending <= 1'b0;
    end else begin
      state         <= state_nx;
      mem_req       <= mem_req_nx;
      mem_addr      <= mem_addr_nx;
      instr         <= instr_nx;
      instr_pc      <= instr_pc_nx;
      instr_valid   <= instr_valid_nx;
      pc_en         <= pc_en_nx;
      fetch_err     <= fetch_err_nx;
      wait_cnt      <= wait_cnt_nx;
      flush_pending <= flush_pending_nx;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. The bench plays the program
// counter (advancing by 4 on each pc_en pulse, loading jump targets on
// redirects) and the instruction memory (acking after a chosen latency).
// Every word handed to the DUT with a non-discarded ack is pushed into a
// scoreboard queue together with its address; a monitor pops an entry each
// time instr_valid rises and compares instr and instr_pc against it.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int          ADDR_W  = 32;
  localparam int          DATA_W  = 32;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] pc_in;
  logic              flush;
  logic              pc_en;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              fetch_err;

  int check_count      = 0;
  int fail_count       = 0;
  int pc_en_count      = 0;
  int valid_rise_count = 0;
  int kept_fetches     = 0;

  logic [DATA_W-1:0] exp_instr_q[$];
  logic [ADDR_W-1:0] exp_pc_q[$];
  logic              valid_q = 1'b0;

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .TIMEOUT  (TIMEOUT),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .flush      (flush),
    .pc_en      (pc_en),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .fetch_err  (fetch_err)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case some wait is never satisfied.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // One clock: outputs are sampled 1 ns after the rising edge. The bench
  // acts as the program counter, so a pc_en pulse advances pc_in by 4.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst && pc_en) pc_in = pc_in + 32'd4;
  endtask

  // Scoreboard monitor: each new valid instruction must match the oldest
  // expected entry.
  initial begin : monitor
    logic [DATA_W-1:0] e_instr;
    logic [ADDR_W-1:0] e_pc;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (pc_en) pc_en_count++;
        if (instr_valid && !valid_q) begin
          valid_rise_count++;
          if (exp_instr_q.size() == 0) begin
            checkOutput("unexpected_valid", 64'(instr_valid), 64'd0);
          end else begin
            e_instr = exp_instr_q.pop_front();
            e_pc    = exp_pc_q.pop_front();
            checkOutput("sb_instr", 64'(instr), 64'(e_instr));
            checkOutput("sb_instr_pc", 64'(instr_pc), 64'(e_pc));
          end
        end
      end
      valid_q = instr_valid;
    end
  end

  // Hold reset for two edges, check the reset values, then release.
  task automatic applyReset();
    rst     = 1'b1;
    mem_ack = 1'b0;
    flush   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_instr", 64'(instr), 64'(NOP));
    checkOutput("rst_instr_pc", 64'(instr_pc), 64'd0);
    checkOutput("rst_instr_valid", 64'(instr_valid), 64'd0);
    checkOutput("rst_pc_en", 64'(pc_en), 64'd0);
    checkOutput("rst_fetch_err", 64'(fetch_err), 64'd0);
    rst = 1'b0;
  endtask

  // Bounded wait for a fetch request.
  task automatic waitForReq(output bit seen);
    int n;
    n = 0;
    while (!mem_req && n < 12) begin
      tick();
      n++;
    end
    seen = mem_req;
    checkOutput("req_seen", 64'(mem_req), 64'd1);
  endtask

  // One complete fetch: wait for the request, check its address, keep it
  // pending for 'latency' cycles, then ack with 'data'. With hold_ready the
  // decode side refuses the instruction; otherwise the post-ack cycle is
  // checked for a single pc_en pulse and the valid drop.
  task automatic applyStimulus(input int latency, input logic [DATA_W-1:0] data,
                               input logic [ADDR_W-1:0] exp_addr, input bit hold_ready);
    bit seen;
    waitForReq(seen);
    if (!seen) return;
    checkOutput("mem_addr", 64'(mem_addr), 64'(exp_addr));
    for (int i = 0; i < latency; i++) begin
      tick();
      checkOutput("req_held", 64'({mem_req, mem_addr}), 64'({1'b1, exp_addr}));
    end
    instr_ready = hold_ready ? 1'b0 : 1'b1;
    mem_ack     = 1'b1;
    mem_rdata   = data;
    exp_instr_q.push_back(data);
    exp_pc_q.push_back(exp_addr);
    kept_fetches++;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = $urandom();
    checkOutput("ack_valid", 64'(instr_valid), 64'd1);
    checkOutput("ack_pc_en", 64'(pc_en), 64'd1);
    checkOutput("ack_mem_req", 64'(mem_req), 64'd0);
    if (!hold_ready) begin
      tick();
      checkOutput("pc_en_single", 64'(pc_en), 64'd0);
      checkOutput("valid_drop", 64'(instr_valid), 64'd0);
    end
  endtask

  initial begin : main
    bit seen;
    int n;
    logic [DATA_W-1:0] word;

    rst         = 1'b1;
    pc_in       = '0;
    flush       = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    instr_ready = 1'b1;

    // Basic fetch from address 0 with a 2-cycle ack.
    $display("[TB] basic fetch");
    applyReset();
    applyStimulus(2, 32'h8C01_0004, 32'h0, 1'b0);
    checkOutput("pc_advanced", 64'(pc_in), 64'h4);

    // Back-to-back fetches with random ack latency.
    $display("[TB] back-to-back fetches");
    for (int i = 1; i <= 8; i++) begin
      word = $urandom();
      applyStimulus(int'($urandom_range(0, 3)), word, ADDR_W'(4 * i), 1'b0);
    end

    // Decode stalls for 5 cycles, then accepts.
    $display("[TB] decode stall");
    applyStimulus(1, 32'h1234_5678, 32'h24, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_instr", 64'(instr), 64'h1234_5678);
      checkOutput("stall_instr_pc", 64'(instr_pc), 64'h24);
      checkOutput("stall_valid", 64'(instr_valid), 64'd1);
      checkOutput("stall_req", 64'(mem_req), 64'd0);
      checkOutput("stall_pc_en", 64'(pc_en), 64'd0);
    end
    instr_ready = 1'b1;
    tick();
    checkOutput("stall_release", 64'(instr_valid), 64'd0);

    // Redirect while waiting on memory: the late ack is discarded.
    $display("[TB] flush during wait");
    waitForReq(seen);
    checkOutput("flush_req_addr", 64'(mem_addr), 64'h28);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pc_in = 32'd100;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    checkOutput("flush_valid", 64'(instr_valid), 64'd0);
    checkOutput("flush_pc_en", 64'(pc_en), 64'd0);
    checkOutput("flush_req_drop", 64'(mem_req), 64'd0);
    applyStimulus(0, 32'h0042_0042, 32'd100, 1'b0);

    // Redirect while an instruction is held for decode.
    $display("[TB] flush in valid");
    applyStimulus(3, 32'hCAFE_F00D, 32'd104, 1'b1);
    tick();
    checkOutput("hold_valid", 64'(instr_valid), 64'd1);
    flush = 1'b1;
    pc_in = 32'd200;
    tick();
    flush       = 1'b0;
    instr_ready = 1'b1;
    checkOutput("vflush_valid", 64'(instr_valid), 64'd0);
    checkOutput("vflush_instr", 64'(instr), 64'(NOP));
    applyStimulus(1, 32'h1111_2222, 32'd200, 1'b0);

    checkOutput("pc_en_vs_valid", 64'(pc_en_count), 64'(valid_rise_count));
    checkOutput("pc_en_count", 64'(pc_en_count), 64'(kept_fetches));

    // Memory never answers: timeout after TIMEOUT cycles, sticky error.
    $display("[TB] memory timeout");
    waitForReq(seen);
    checkOutput("to_addr", 64'(mem_addr), 64'd204);
    n = 0;
    while (mem_req && n < 40) begin
      tick();
      n++;
    end
    checkOutput("to_cycles", 64'(n), 64'(TIMEOUT));
    checkOutput("to_err", 64'(fetch_err), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("err_sticky", 64'({fetch_err, mem_req, instr_valid}), 64'b100);
    end
    pc_in = 32'h300;
    applyReset();
    applyStimulus(2, 32'hA5A5_5A5A, 32'h300, 1'b0);

    // Asynchronous reset between edges while a request is outstanding.
    $display("[TB] async reset mid-wait");
    waitForReq(seen);
    tick();
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_req", 64'(mem_req), 64'd0);
    checkOutput("async_valid", 64'(instr_valid), 64'd0);
    checkOutput("async_instr", 64'(instr), 64'(NOP));
    pc_in = 32'h400;
    applyReset();
    applyStimulus(1, 32'h0BAD_F00D, 32'h400, 1'b0);

    checkOutput("sb_empty", 64'(exp_instr_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
